// File: rtl/spi_word_fifo.sv
// SPI slave front end: synchronises raw sck/sdi/cen, assembles MSB-first words
// and buffers them in a first-word-fall-through FIFO with a valid/ready output.
module spi_word_fifo #(
    parameter int WORD_W      = 16,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sck,
    input  logic                     sdi,
    input  logic                     cen,
    output logic [WORD_W-1:0]        word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     frame_err,
    output logic                     frame_end
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sck_sr, sdi_sr, cen_sr;
    logic                   sck_prev, cen_prev;
    logic                   sck_s, sdi_s, cen_s, sck_rise, cen_fall;

    state_t              state, state_d;
    logic [CW-1:0]       bitcnt, bitcnt_d;
    logic [WORD_W-1:0]   shreg, shreg_d;
    logic                push, err_set, pop, push_ok;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;

    // The chains carry the live pin levels through reset so that WAIT_IDLE sees
    // the true cen level; only the edge-detect copies are cleared.
    always_ff @(posedge clk) begin
        sck_sr <= {sck_sr[SYNC_STAGES-2:0], sck};
        sdi_sr <= {sdi_sr[SYNC_STAGES-2:0], sdi};
        cen_sr <= {cen_sr[SYNC_STAGES-2:0], cen};
    end

    assign sck_s    = sck_sr[SYNC_STAGES-1];
    assign sdi_s    = sdi_sr[SYNC_STAGES-1];
    assign cen_s    = cen_sr[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign cen_fall = ~cen_s & cen_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_prev  <= 1'b0;
            cen_prev  <= 1'b0;
            state     <= WAIT_IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            frame_end <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sck_prev  <= sck_s;
            cen_prev  <= cen_s;
            state     <= state_d;
            bitcnt    <= bitcnt_d;
            shreg     <= shreg_d;
            frame_end <= cen_fall;
            if (err_set) frame_err <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state;
        bitcnt_d = bitcnt;
        shreg_d  = shreg;
        push     = 1'b0;
        err_set  = 1'b0;
        unique case (state)
            WAIT_IDLE: begin
                bitcnt_d = '0;
                if (!cen_s) state_d = IDLE;
            end
            IDLE: begin
                bitcnt_d = '0;
                if (cen_s) state_d = SHIFT;
            end
            SHIFT: begin
                // The bit is taken before a coincident cen_fall is evaluated.
                if (sck_rise) begin
                    shreg_d = {shreg[WORD_W-2:0], sdi_s};
                    if (bitcnt == LAST_BIT) begin
                        push     = 1'b1;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt + CW'(1);
                    end
                end
                if (cen_fall) begin
                    state_d  = IDLE;
                    err_set  = (bitcnt_d != '0);
                    bitcnt_d = '0;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    assign word_valid = (fifo_count != '0);
    assign word_out   = word_valid ? mem[rd_ptr] : '0;
    assign pop        = word_valid & word_ready;
    assign push_ok    = push & ((fifo_count != FULL) | pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push && !push_ok) overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_word_fifo.sv
// Directed bench for spi_word_fifo: bit-bangs SPI at clk/6 and checks the
// FIFO contents, counts and sticky flags against hand-computed values.
module tb_spi_word_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0, sdi = 1'b0, cen = 1'b0;
    logic [15:0] word_out;
    logic        word_valid, word_ready = 1'b0;
    logic [3:0]  fifo_count;
    logic        overflow, frame_err, frame_end;

    int checks = 0;
    int failures = 0;
    int fe_cnt = 0;
    int fe_base;

    spi_word_fifo dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cen(cen),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err),
        .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_end) fe_cnt <= fe_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 15; i > 15 - n; i--) begin
            sdi = w[i];
            sck = 1'b0;
            cyc(3);
            sck = 1'b1;
            cyc(3);
        end
    endtask

    task automatic begin_tx();
        cen = 1'b1;
        cyc(4);
    endtask

    task automatic end_tx();
        cyc(3);
        cen = 1'b0;
        cyc(1);
        sck = 1'b0;
        cyc(8);
    endtask

    initial begin
        cyc(4);
        reset = 1'b0;
        cyc(2);
        // reset state
        chk("rst_valid", word_valid, 0);
        chk("rst_word", word_out, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_fend", frame_end, 0);

        // single word
        fe_base = fe_cnt;
        begin_tx(); send_bits(16'hA5C3, 16); end_tx();
        chk("t1_valid", word_valid, 1);
        chk("t1_word", word_out, 16'hA5C3);
        chk("t1_count", fifo_count, 1);
        chk("t1_fend", fe_cnt - fe_base, 1);
        chk("t1_ferr", frame_err, 0);

        // three words in one transaction, drained back-to-back
        do_reset();
        chk("t2_rst_count", fifo_count, 0);
        begin_tx();
        send_bits(16'h1111, 16); send_bits(16'h2222, 16); send_bits(16'h3333, 16);
        end_tx();
        chk("t2_count3", fifo_count, 3);
        chk("t2_w0", word_out, 16'h1111);
        word_ready = 1'b1;
        cyc(1);
        chk("t2_count2", fifo_count, 2);
        chk("t2_w1", word_out, 16'h2222);
        cyc(1);
        chk("t2_count1", fifo_count, 1);
        chk("t2_w2", word_out, 16'h3333);
        cyc(1);
        chk("t2_count0", fifo_count, 0);
        chk("t2_valid0", word_valid, 0);
        word_ready = 1'b0;

        // overflow: nine words into eight entries
        do_reset();
        begin_tx();
        for (int i = 0; i < 9; i++) send_bits(16'hC000 + 16'(i), 16);
        end_tx();
        chk("t3_count", fifo_count, 8);
        chk("t3_ovf", overflow, 1);
        word_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_rd%0d", i), word_out, 16'hC000 + 16'(i));
            cyc(1);
        end
        word_ready = 1'b0;
        chk("t3_empty", fifo_count, 0);
        chk("t3_ovf_sticky", overflow, 1);

        // partial word then a full one
        do_reset();
        chk("t4_ovf_clr", overflow, 0);
        begin_tx(); send_bits(16'hFFFF, 5); end_tx();
        chk("t4_ferr", frame_err, 1);
        chk("t4_count0", fifo_count, 0);
        begin_tx(); send_bits(16'h00FF, 16); end_tx();
        chk("t4_count", fifo_count, 1);
        chk("t4_word", word_out, 16'h00FF);
        chk("t4_ferr_sticky", frame_err, 1);

        // reset in the middle of a word while cen stays high
        do_reset();
        begin_tx(); send_bits(16'h1234, 8);
        reset = 1'b1; cyc(1); reset = 1'b0;
        send_bits(16'h0034, 8); end_tx();
        chk("t5_count0", fifo_count, 0);
        begin_tx(); send_bits(16'hBEEF, 16); end_tx();
        chk("t5_count", fifo_count, 1);
        chk("t5_word", word_out, 16'hBEEF);
        chk("t5_ferr", frame_err, 0);

        // push into full FIFO in the same cycle as a pop
        do_reset();
        begin_tx();
        for (int i = 0; i < 8; i++) send_bits(16'h5A00 + 16'(i), 16);
        cyc(4);
        chk("t6_full", fifo_count, 8);
        send_bits(16'h5A08, 15);
        sdi = 1'b0; sck = 1'b0; cyc(3);
        sck = 1'b1; cyc(2);
        word_ready = 1'b1; cyc(1);
        word_ready = 1'b0;
        chk("t6_count", fifo_count, 8);
        chk("t6_ovf", overflow, 0);
        chk("t6_head", word_out, 16'h5A01);
        end_tx();
        word_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("t6_rd%0d", i), word_out, 16'h5A00 + 16'(i));
            cyc(1);
        end
        word_ready = 1'b0;
        chk("t6_empty", word_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
